pc_sequencer: RTL and testbench

- Program-counter and hardware-stack sequencer for the PIC16C5x core.
- Holds the fetch address. Advances it once per instruction cycle on the Q4 strobe from the control unit.
- Applies GOTO/CALL/RETLW/PCL-write redirects and FSZ/BTFSx skips, and owns the return-address stack.
- Drives a flush flag so the already-fetched instruction executes as a NOP after any redirect or skip.

---
 rtl/pc_sequencer.sv | 88 ++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PIC16C5x program counter and return-address stack sequencer.
// All state advances only on a qualified Q4 step (step_en && !hold).
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 9,
  parameter int unsigned          STACK_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(9'h1FF)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               step_en,
  input  logic                               hold,
  input  logic [1:0]                         stk_cmd,
  input  logic                               jump_en,
  input  logic [PC_WIDTH-1:0]                jump_addr,
  input  logic                               pcl_we,
  input  logic [7:0]                         pcl_data,
  input  logic                               skip_req,
  output logic [PC_WIDTH-1:0]                pc,
  output logic                               flush,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_depth,
  output logic                               stk_ovf,
  output logic                               stk_unf
);

  localparam int unsigned    DW   = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0]  FULL = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_RSVD = 2'b11
  } stk_cmd_e;

  stk_cmd_e             cmd;
  logic [PC_WIDTH-1:0]  stk [STACK_DEPTH];
  logic [PC_WIDTH-1:0]  pc_inc;

  always_comb begin
    cmd    = stk_cmd_e'(stk_cmd);
    pc_inc = pc + PC_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_VECTOR;
      flush     <= 1'b1;
      stk_depth <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else if (step_en && !hold) begin
      if (cmd == CMD_POP) begin
        // POP overrides every other request; the bottom entry duplicates.
        pc    <= stk[0];
        flush <= 1'b1;
        for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) stk[i] <= stk[i+1];
        if (stk_depth != '0) stk_depth <= stk_depth - DW'(1);
        else                 stk_unf   <= 1'b1;
      end else begin
        if (cmd == CMD_PUSH) begin
          stk[0] <= pc;
          for (int unsigned i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
          if (stk_depth != FULL) stk_depth <= stk_depth + DW'(1);
          else                   stk_ovf   <= 1'b1;
        end
        // A PUSH lacking its jump just falls through to the next address.
        if (jump_en) begin
          pc    <= jump_addr;
          flush <= 1'b1;
        end else if (cmd == CMD_PUSH) begin
          pc    <= pc_inc;
          flush <= 1'b0;
        end else if (pcl_we) begin
          pc    <= PC_WIDTH'(pcl_data);
          flush <= 1'b1;
        end else if (skip_req) begin
          pc    <= pc_inc;
          flush <= 1'b1;
        end else begin
          pc    <= pc_inc;
          flush <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected outputs queued per step, then checked.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_en;
  logic       hold;
  logic [1:0] stk_cmd;
  logic       jump_en;
  logic [8:0] jump_addr;
  logic       pcl_we;
  logic [7:0] pcl_data;
  logic       skip_req;
  logic [8:0] pc;
  logic       flush;
  logic [1:0] stk_depth;
  logic       stk_ovf;
  logic       stk_unf;

  typedef struct packed {
    logic [8:0] pc;
    logic       flush;
    logic [1:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    checks = 0;
  int    errors = 0;

  pc_sequencer #(
    .PC_WIDTH    (9),
    .STACK_DEPTH (2),
    .RESET_VECTOR(9'h1FF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en  (step_en),
    .hold     (hold),
    .stk_cmd  (stk_cmd),
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
    .pcl_we   (pcl_we),
    .pcl_data (pcl_data),
    .skip_req (skip_req),
    .pc       (pc),
    .flush    (flush),
    .stk_depth(stk_depth),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [8:0] e_pc, input logic e_fl,
                            input logic [1:0] e_d, input logic e_ovf, input logic e_unf);
    exp_t e;
    e.pc = e_pc; e.flush = e_fl; e.depth = e_d; e.ovf = e_ovf; e.unf = e_unf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries, required >= 1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (pc === e.pc) else begin
        errors++; $error("FAIL %s pc: got %h, required %h", t, pc, e.pc);
      end
      checks++;
      assert (flush === e.flush) else begin
        errors++; $error("FAIL %s flush: got %b, required %b", t, flush, e.flush);
      end
      checks++;
      assert (stk_depth === e.depth) else begin
        errors++; $error("FAIL %s depth: got %0d, required %0d", t, stk_depth, e.depth);
      end
      checks++;
      assert (stk_ovf === e.ovf) else begin
        errors++; $error("FAIL %s ovf: got %b, required %b", t, stk_ovf, e.ovf);
      end
      checks++;
      assert (stk_unf === e.unf) else begin
        errors++; $error("FAIL %s unf: got %b, required %b", t, stk_unf, e.unf);
      end
    end
  endtask

  task automatic clear_req();
    step_en = 1'b0; stk_cmd = 2'b00; jump_en = 1'b0; jump_addr = '0;
    pcl_we = 1'b0; pcl_data = '0; skip_req = 1'b0;
  endtask

  // One qualified step pulse with the given requests, then check the queued result.
  task automatic step(input logic [1:0] cmd, input logic jmp, input logic [8:0] addr,
                      input logic pwe, input logic [7:0] pdat, input logic skp);
    @(negedge clk);
    stk_cmd = cmd; jump_en = jmp; jump_addr = addr;
    pcl_we = pwe; pcl_data = pdat; skip_req = skp; step_en = 1'b1;
    @(posedge clk);
    #1;
    clear_req();
    compare_out();
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    clear_req();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 9'h1FF, 1'b1, 2'd0, 1'b0, 1'b0);
    compare_out();
    @(negedge clk); rst_n = 1'b1;

    expect_out("seq0", 9'h000, 1'b0, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("seq1", 9'h001, 1'b0, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("seq2", 9'h002, 1'b0, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);

    // Requests without step_en must not change anything.
    @(negedge clk); jump_en = 1'b1; jump_addr = 9'h123; stk_cmd = 2'b01;
    repeat (3) @(posedge clk);
    #1; clear_req();
    expect_out("no_step", 9'h002, 1'b0, 2'd0, 1'b0, 1'b0);
    compare_out();

    // CALL/RETLW round trip.
    expect_out("goto010", 9'h010, 1'b1, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b1, 9'h010, 1'b0, 8'h00, 1'b0);
    expect_out("call0a5", 9'h0A5, 1'b1, 2'd1, 1'b0, 1'b0); step(2'b01, 1'b1, 9'h0A5, 1'b0, 8'h00, 1'b0);
    expect_out("ret010",  9'h010, 1'b1, 2'd0, 1'b0, 1'b0); step(2'b10, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("after_ret", 9'h011, 1'b0, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);

    // Overflow then underflow.
    expect_out("goto020", 9'h020, 1'b1, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b1, 9'h020, 1'b0, 8'h00, 1'b0);
    expect_out("call_a",  9'h030, 1'b1, 2'd1, 1'b0, 1'b0); step(2'b01, 1'b1, 9'h030, 1'b0, 8'h00, 1'b0);
    expect_out("call_b",  9'h040, 1'b1, 2'd2, 1'b0, 1'b0); step(2'b01, 1'b1, 9'h040, 1'b0, 8'h00, 1'b0);
    expect_out("call_ovf", 9'h050, 1'b1, 2'd2, 1'b1, 1'b0); step(2'b01, 1'b1, 9'h050, 1'b0, 8'h00, 1'b0);
    expect_out("pop1", 9'h040, 1'b1, 2'd1, 1'b1, 1'b0); step(2'b10, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("pop2", 9'h030, 1'b1, 2'd0, 1'b1, 1'b0); step(2'b10, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("pop_unf", 9'h030, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b10, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);

    // PCL write clears bit 8; skip.
    expect_out("goto1a0", 9'h1A0, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b1, 9'h1A0, 1'b0, 8'h00, 1'b0);
    expect_out("pcl7f",   9'h07F, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b0, 9'h000, 1'b1, 8'h7F, 1'b0);
    expect_out("goto050", 9'h050, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b1, 9'h050, 1'b0, 8'h00, 1'b0);
    expect_out("skip",    9'h051, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b1);
    expect_out("post_skip", 9'h052, 1'b0, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("jump_over_pcl", 9'h0C3, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b1, 9'h0C3, 1'b1, 8'h11, 1'b1);
    expect_out("pcl_over_skip", 9'h022, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b0, 9'h000, 1'b1, 8'h22, 1'b1);

    // PUSH without jump, then POP beating every other request, then reserved cmd.
    expect_out("push_nojump", 9'h023, 1'b0, 2'd1, 1'b1, 1'b1); step(2'b01, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    expect_out("pop_wins", 9'h022, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b10, 1'b1, 9'h155, 1'b1, 8'h33, 1'b1);
    expect_out("cmd11_nop", 9'h023, 1'b0, 2'd0, 1'b1, 1'b1); step(2'b11, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);

    // Wraparound 1FF -> 000.
    expect_out("goto1ff", 9'h1FF, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b1, 9'h1FF, 1'b0, 8'h00, 1'b0);
    expect_out("wrap", 9'h000, 1'b0, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);

    // Hold suppresses steps.
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_out("hold", 9'h000, 1'b0, 2'd0, 1'b1, 1'b1);
      step(2'b01, 1'b1, 9'h0AA, 1'b0, 8'h00, 1'b0);
    end
    hold = 1'b0;
    expect_out("hold_release", 9'h0AA, 1'b1, 2'd0, 1'b1, 1'b1); step(2'b00, 1'b1, 9'h0AA, 1'b0, 8'h00, 1'b0);

    // Reset coincident with a POP at depth 1.
    expect_out("call0b0", 9'h0B0, 1'b1, 2'd1, 1'b1, 1'b1); step(2'b01, 1'b1, 9'h0B0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; stk_cmd = 2'b10; step_en = 1'b1;
    @(posedge clk);
    #1; clear_req();
    expect_out("reset_mid_pop", 9'h1FF, 1'b1, 2'd0, 1'b0, 1'b0);
    compare_out();
    @(negedge clk); rst_n = 1'b1;
    expect_out("post_reset", 9'h000, 1'b0, 2'd0, 1'b0, 1'b0); step(2'b00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);
    // Stack contents cleared by reset: a pop returns 000.
    expect_out("pop_after_reset", 9'h000, 1'b1, 2'd0, 1'b0, 1'b1); step(2'b10, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
